cpu_pc_vec: RTL

Parametrised program-counter unit for the matiz RISC-V core; successor to the single-interrupt PC block. Computes the next fetch address from sequential, branch, JAL and JALR requests. Adds NUM_IRQ prioritised, individually enabled interrupt channels with vectored entry, a saved return PC (EPC), and an `mret` return path. Sits between the decode/ALU stage and instruction fetch.

---
 rtl/cpu_pc_pkg.sv | 19 +
 rtl/cpu_pc_vec_if.sv | 43 ++++
 rtl/cpu_pc_irq_prio.sv | 25 ++
 rtl/cpu_pc_vec.sv | 130 +++++++++++++
 4 files changed

// File: rtl/cpu_pc_pkg.sv
// Shared types and defaults for the vectored PC unit.
// Optional misalign trap: CPU_PC_ALIGN_TRAP_EN.
package cpu_pc_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } pc_state_e;

  localparam int          PC_INC         = 4;
  localparam logic [31:0] DEF_RESET_VEC  = 32'h0000_0000;
  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
  localparam int          DEF_VEC_STRIDE = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_pc_vec_if.sv
// Decode/ALU <-> PC unit bundle.
// Master: decode side; slave: PC unit.
interface cpu_pc_vec_if
  import cpu_pc_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 4
);
  localparam int IRQ_W = idx_w(NUM_IRQ);

  logic               stall;
  logic [XLEN-1:0]    offset;
  logic               branch;
  logic               zero;
  logic               jal;
  logic               jalr;
  logic [XLEN-1:0]    result_from_alu;
  logic               mret;
  logic [NUM_IRQ-1:0] interrupt;
  logic [NUM_IRQ-1:0] irq_enable;
  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    epc;
  logic [NUM_IRQ-1:0] interrupt_grant;
  logic               irq_active;
  logic [IRQ_W-1:0]   irq_id;

  modport master (
    output stall, offset, branch, zero,
    output jal, jalr, result_from_alu, mret,
    output interrupt, irq_enable,
    input  pc, epc, interrupt_grant,
    input  irq_active, irq_id
  );

  modport slave (
    input  stall, offset, branch, zero,
    input  jal, jalr, result_from_alu, mret,
    input  interrupt, irq_enable,
    output pc, epc, interrupt_grant,
    output irq_active, irq_id
  );

endinterface

// File: rtl/cpu_pc_irq_prio.sv
// Lowest-index-wins priority encoder for
// pending interrupt requests.
module cpu_pc_irq_prio
  import cpu_pc_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int IRQ_W   = idx_w(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] pending,
  output logic               valid,
  output logic [IRQ_W-1:0]   winner,
  output logic [NUM_IRQ-1:0] onehot
);

  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) winner = IRQ_W'(i);
    end
  end

  assign valid  = |pending;
  assign onehot = pending & (~pending + NUM_IRQ'(1));

endmodule

// File: rtl/cpu_pc_vec.sv
// Program counter with vectored, prioritised interrupts.
// Optional misalign trap: CPU_PC_ALIGN_TRAP_EN.
module cpu_pc_vec
  import cpu_pc_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              NUM_IRQ    = 4,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] VEC_BASE   = XLEN'(DEF_VEC_BASE),
  parameter int              VEC_STRIDE = DEF_VEC_STRIDE
) (
  input logic         clk,
  input logic         reset,
  cpu_pc_vec_if.slave bus
);

  localparam int IRQ_W = idx_w(NUM_IRQ);

  pc_state_e          state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    epc_q, epc_d;
  logic [IRQ_W-1:0]   id_q, id_d;
  logic [NUM_IRQ-1:0] gnt_q, gnt_d;

  logic [NUM_IRQ-1:0] pend, win_oh;
  logic [IRQ_W-1:0]   win;
  logic               pend_v;
  logic [XLEN-1:0]    seq, br_tgt, jt;
  logic [XLEN-1:0]    vec_pc, trap_pc;
  logic               misalign;

  assign pend = bus.interrupt & bus.irq_enable;

  cpu_pc_irq_prio #(
    .NUM_IRQ (NUM_IRQ),
    .IRQ_W   (IRQ_W)
  ) u_prio (
    .pending (pend),
    .valid   (pend_v),
    .winner  (win),
    .onehot  (win_oh)
  );

  assign seq    = pc_q + XLEN'(PC_INC);
  assign br_tgt = pc_q + bus.offset;

  always_comb begin
    jt = seq;
    if (bus.jalr)
      jt = {bus.result_from_alu[XLEN-1:1], 1'b0};
    else if (bus.jal || (bus.branch && bus.zero))
      jt = br_tgt;
  end

  assign vec_pc  = VEC_BASE
                 + XLEN'(win) * XLEN'(VEC_STRIDE);
  assign trap_pc = VEC_BASE - XLEN'(VEC_STRIDE);

`ifdef CPU_PC_ALIGN_TRAP_EN
  logic redirect;
  assign redirect = bus.jalr | bus.jal
                  | (bus.branch & bus.zero);
  assign misalign = redirect & jt[1];
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    state_d = state_q;
    id_d    = id_q;
    gnt_d   = '0;
    if (!bus.stall) begin
      unique case (state_q)
        RUN: begin
          if (misalign) begin
            pc_d    = trap_pc;
            epc_d   = pc_q;
            state_d = HANDLER;
          end else if (pend_v) begin
            // epc keeps this cycle's redirect
            pc_d    = vec_pc;
            epc_d   = jt;
            id_d    = win;
            gnt_d   = win_oh;
            state_d = HANDLER;
          end else begin
            pc_d = jt;
          end
        end
        HANDLER: begin
          if (bus.mret) begin
            pc_d    = epc_q;
            state_d = RUN;
          end else if (misalign) begin
            pc_d  = trap_pc;
            epc_d = pc_q;
          end else begin
            pc_d = jt;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.pc              = pc_q;
  assign bus.epc             = epc_q;
  assign bus.interrupt_grant = gnt_q;
  assign bus.irq_active      = (state_q == HANDLER);
  assign bus.irq_id          = id_q;

endmodule
